writeback_arbiter_escalar: RTL and testbench

- Drives the single write port (we3/a3/wd3) of the scalar register file.
- Accepts results from two producers, the ALU and the memory load path, using valid/ready handshakes.
- Arbitrates between them round-robin and buffers accepted writes in an in-order FIFO.
- Issues at most one register write per cycle and exports a pending-write mask that the hazard logic uses to stall dependent reads.

---
 rtl/writeback_arbiter_escalar.sv | 147 ++++++++++++++
 tb/tb_writeback_arbiter_escalar.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter_escalar.sv
// Write-back arbiter for the scalar register file: round-robin between ALU and
// load results, in-order FIFO, one registered write per cycle, pending-write mask.
module writeback_arbiter_escalar #(
  parameter int unsigned REGISTERS = 32,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [$clog2(REGISTERS)-1:0] alu_rd,
  input  logic [WIDTH-1:0]             alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [$clog2(REGISTERS)-1:0] mem_rd,
  input  logic [WIDTH-1:0]             mem_data,
  input  logic                         wb_stall,
  output logic                         we3,
  output logic [$clog2(REGISTERS)-1:0] a3,
  output logic [WIDTH-1:0]             wd3,
  output logic [REGISTERS-1:0]         pend_mask,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(REGISTERS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_e;

  prio_e            prio_q, prio_d;
  logic [AW-1:0]    fifo_rd_q   [DEPTH];
  logic [AW-1:0]    fifo_rd_d   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             we3_q, we3_d;
  logic [AW-1:0]    a3_q, a3_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;

  logic             full;
  logic             alu_fire;
  logic             mem_fire;
  logic             push;
  logic             pop;
  logic [AW-1:0]    in_rd;
  logic [WIDTH-1:0] in_data;

  assign full      = (count_q == CW'(DEPTH));
  assign alu_ready = !full && (!mem_valid || (prio_q == PRIO_ALU));
  assign mem_ready = !full && (!alu_valid || (prio_q == PRIO_MEM));
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign in_rd     = alu_fire ? alu_rd   : mem_rd;
  assign in_data   = alu_fire ? alu_data : mem_data;
  // x0 writes complete the handshake but are dropped before the FIFO
  assign push      = (alu_fire || mem_fire) && (in_rd != '0);
  assign pop       = !wb_stall && (count_q != '0);

  always_comb begin
    prio_d      = prio_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    we3_d       = 1'b0;
    a3_d        = a3_q;
    wd3_d       = wd3_q;

    if (alu_valid && mem_valid && !full) begin
      prio_d = (prio_q == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
    end

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = in_rd;
      fifo_data_d[wr_ptr_q] = in_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      we3_d    = 1'b1;
      a3_d     = fifo_rd_q[rd_ptr_q];
      wd3_d    = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    logic [PW-1:0] idx;
    pend_mask = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        pend_mask[fifo_rd_q[idx]] = 1'b1;
      end
    end
    if (we3_q) begin
      pend_mask[a3_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= PRIO_ALU;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      prio_q      <= prio_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      we3_q       <= we3_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign we3   = we3_q;
  assign a3    = a3_q;
  assign wd3   = wd3_q;
  assign count = count_q;

endmodule

// File: tb/tb_writeback_arbiter_escalar.sv
// Directed bench for writeback_arbiter_escalar with a small register-file model
// and a write-port monitor.
module tb_writeback_arbiter_escalar;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [15:0] mem_data;
  logic        wb_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [15:0] wd3;
  logic [31:0] pend_mask;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] rf [32];
  logic [4:0]  wa  [$];
  logic [15:0] wdq [$];
  int          wc  [$];

  writeback_arbiter_escalar #(.REGISTERS(32), .WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_stall(wb_stall), .we3(we3), .a3(a3), .wd3(wd3),
    .pend_mask(pend_mask), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (we3) rf[a3] <= wd3;

  always @(posedge clk) begin
    #1;
    if (rst_n && we3) begin
      wa.push_back(a3);
      wdq.push_back(wd3);
      wc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [15:0] d);
    bit ok = 1'b0;
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1 ok = alu_ready;
      @(negedge clk);
    end
    alu_valid = 1'b0;
    if (!ok) chk("alu_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [15:0] d);
    bit ok = 1'b0;
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1 ok = mem_ready;
      @(negedge clk);
    end
    mem_valid = 1'b0;
    if (!ok) chk("mem_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ea [4];
    int eb [5];
    int ai, mi;
    logic exp_alu;
    ea = '{1, 9, 2, 10};
    eb = '{1, 2, 3, 4, 6};

    rst_n = 1'b0; wb_stall = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_wd3", 32'(wd3), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single ALU write, latency and pend window
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 16'h1234;
    #1 chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_pend_q", pend_mask, 32'h20);
    chk("t1_we3_early", 32'(we3), 32'd0);
    @(negedge clk);
    chk("t1_we3", 32'(we3), 32'd1);
    chk("t1_a3", 32'(a3), 32'd5);
    chk("t1_wd3", 32'(wd3), 32'h1234);
    chk("t1_pend_port", pend_mask, 32'h20);
    chk("t1_count0", 32'(count), 32'd0);
    @(negedge clk);
    chk("t1_we3_drop", 32'(we3), 32'd0);
    chk("t1_pend_clr", pend_mask, 32'd0);
    chk("t1_rf5", 32'(rf[5]), 32'h1234);

    // 2: round-robin with both producers valid
    wa.delete(); wdq.delete(); wc.delete();
    ai = 0; mi = 0;
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + ai); alu_data = 16'hA000 + 16'(1 + ai);
      mem_valid = 1'b1; mem_rd = 5'(9 + mi); mem_data = 16'hB000 + 16'(9 + mi);
      exp_alu = (c % 2 == 0);
      #1;
      chk("t2_alu_ready", 32'(alu_ready), 32'(exp_alu));
      chk("t2_mem_ready", 32'(mem_ready), 32'(!exp_alu));
      if (exp_alu) ai++; else mi++;
      @(negedge clk);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_nwrites", wa.size(), 32'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk("t2_a3", 32'(wa[i]), 32'(ea[i]));
      chk("t2_wd3", 32'(wdq[i]), (ea[i] < 9) ? 32'hA000 + 32'(ea[i]) : 32'hB000 + 32'(ea[i]));
    end

    // 3: x0 write is accepted and dropped
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 16'hFFFF;
    #1 chk("t3_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("t3_count", 32'(count), 32'd0);
    chk("t3_pend", pend_mask, 32'd0);
    @(negedge clk);
    chk("t3_we3", 32'(we3), 32'd0);

    // 4: fill under stall, hold a fifth request, then drain
    wa.delete(); wdq.delete(); wc.delete();
    wb_stall = 1'b1;
    for (int r = 1; r <= 4; r++) drive_alu(5'(r), 16'hA000 + 16'(r));
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_pend", pend_mask, 32'h1E);
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 16'hA006;
    #1;
    chk("t4_alu_ready_full", 32'(alu_ready), 32'd0);
    chk("t4_mem_ready_full", 32'(mem_ready), 32'd0);
    @(negedge clk);
    chk("t4_count_held", 32'(count), 32'd4);
    chk("t4_we3_stalled", 32'(we3), 32'd0);
    wb_stall = 1'b0;
    drive_alu(5'd6, 16'hA006);
    repeat (6) @(negedge clk);
    chk("t4_nwrites", wa.size(), 32'd5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      chk("t4_a3", 32'(wa[i]), 32'(eb[i]));
      chk("t4_wd3", 32'(wdq[i]), 32'hA000 + 32'(eb[i]));
      chk("t4_consec", 32'(wc[i] - wc[0]), 32'(i));
    end

    // 5: same register twice, later value wins
    drive_alu(5'd7, 16'h0001);
    drive_mem(5'd7, 16'h0002);
    chk("t5_pend7_a", 32'(pend_mask[7]), 32'd1);
    chk("t5_we3_a", 32'(we3), 32'd1);
    chk("t5_wd3_a", 32'(wd3), 32'h0001);
    @(negedge clk);
    chk("t5_pend7_b", 32'(pend_mask[7]), 32'd1);
    chk("t5_we3_b", 32'(we3), 32'd1);
    chk("t5_wd3_b", 32'(wd3), 32'h0002);
    @(negedge clk);
    chk("t5_pend7_c", 32'(pend_mask[7]), 32'd0);
    chk("t5_rf7", 32'(rf[7]), 32'h0002);

    // 6: asynchronous reset with queued writes; priority left at MEM beforehand
    wa.delete(); wdq.delete(); wc.delete();
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 16'hC003;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 16'hC004;
    #1 chk("t6_grant_alu", 32'(alu_ready), 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    #1 chk("t6_grant_mem", 32'(mem_ready), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    drive_alu(5'd5, 16'hC005);
    chk("t6_count3", 32'(count), 32'd3);
    chk("t6_pend", pend_mask, 32'h38);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_we3", 32'(we3), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_pend", pend_mask, 32'd0);
    rst_n = 1'b1;
    wb_stall = 1'b0;
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("t6_prio_alu", 32'(alu_ready), 32'd1);
    chk("t6_prio_mem", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_stale_we3", 32'(we3), 32'd0);
    end
    chk("t6_count_after", 32'(count), 32'd0);
    chk("t6_no_writes", wa.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
